ex_mem_pipe_stage: RTL and testbench
====================================

Name: ex_mem_pipe_stage

Overview:
Parametrised EX/MEM pipeline stage with a valid/ready handshake, sitting between the execute stage and the memory stage. It carries the control bits, zero flag, ALU result, store data and destination register. Unlike a plain always-enabled register, it supports backpressure from MEM, an optional skid buffer for full throughput under stall, and a synchronous flush that inserts a bubble. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
CTRL_W, 4, width of control bundle {MemWrite, MemRead, MemToReg, RegWrite} or wider; must be at least 1
DATA_W, 32, width of ALU result and store data
REG_W, 5, destination register index width
SKID, 1, 1 = two-entry skid buffer (in_ready registered, full throughput); 0 = single entry (in_ready combinational)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  EX presents a valid instruction
in_ready  output  1  stage can accept this cycle
ctrl_in  input  CTRL_W  control bundle
zero_in  input  1  ALU zero flag
alu_result_in  input  DATA_W  ALU result / address
write_data_in  input  DATA_W  store data
dest_reg_in  input  REG_W  destination register
out_valid  output  1  MEM-side entry valid
out_ready  input  1  MEM consumes this cycle
ctrl_out  output  CTRL_W  control bundle; forced 0 when out_valid=0
zero_out  output  1  zero flag; forced 0 when out_valid=0
alu_result_out  output  DATA_W  held payload
write_data_out  output  DATA_W  held payload
dest_reg_out  output  REG_W  held payload
occupancy  output  2  entries held (0..2; max 1 when SKID=0)
stall_cycles  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (async, immediate, any state): out_valid=0, occupancy=0, all payload registers 0, stall_cycles=0. in_ready=1 while rst=0 and flush=0.
- Events: accept = in_valid & in_ready; drain = out_valid & out_ready. Both are sampled at the rising clk edge.
- Latency: an accepted entry appears on the outputs with out_valid=1 on the next cycle.
- Ordering: strictly FIFO; no entry is dropped or duplicated except by flush or rst.
- SKID=1 storage: main register M drives the outputs; skid register S holds the overflow entry.
- SKID=1 states:
  - EMPTY (occ 0): accept -> ONE, M<=in.
  - ONE (occ 1): accept & drain -> ONE, M<=in. accept & !drain -> FULL, S<=in. drain & !accept -> EMPTY. Neither -> hold.
  - FULL (occ 2): drain -> ONE, M<=S. Otherwise hold.
  - in_ready = (state != FULL) & !flush. This is a registered state decode with no combinational path from out_ready.
- SKID=0 storage: single register M.
  - in_ready = (!out_valid | out_ready) & !flush. This is a combinational path from out_ready.
  - accept loads M and sets out_valid=1.
  - drain & !accept clears out_valid.
  - accept & drain replaces M with no bubble.
- Flush (synchronous, highest priority after rst):
  - Next state is EMPTY with out_valid=0.
  - in_ready is forced 0 while flush=1, so no accept occurs that cycle.
  - A drain in the same cycle still counts as consumed by MEM.
  - Payload registers are not cleared. Outputs show bubble semantics only through the ctrl_out/zero_out gating.
- Gating: ctrl_out and zero_out = 0 whenever out_valid=0, so a bubble never asserts MemWrite or RegWrite.
- Payload registers load only on the accept/move events above and otherwise hold.
- stall_cycles:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at all-ones and does not wrap.
  - Not affected by flush; cleared only by rst.
- Throughput:
  - SKID=1 sustains 1 entry/cycle with out_ready=1, and absorbs one extra entry on the first cycle out_ready drops.
  - SKID=0 sustains 1 entry/cycle only through the combinational ready path.

Test Plan:
- Streaming: SKID=1, in_valid=1 and out_ready=1 for 8 cycles, alu_result_in=1..8 -> out_valid from cycle 1, alu_result_out=1..8 on consecutive cycles, occupancy=1, stall_cycles=0.
- Backpressure/skid: send A=0x10, B=0x20 with out_ready=0 -> occupancy 1 then 2, in_ready=0 when FULL. Raise out_ready for 2 cycles -> outputs A then B, occupancy 2->1->0, stall_cycles = number of stalled valid cycles.
- Flush: FULL, then flush=1 with in_valid=1 -> next cycle out_valid=0, ctrl_out=0, zero_out=0, occupancy=0. The input presented during flush never appears at the output.
- Async reset mid-stream: rst asserted between clk edges while FULL with ctrl_out=4'b1111 -> out_valid, ctrl_out and occupancy go to 0 immediately, before the next edge. stall_cycles=0.
- SKID=0 mode: out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 in the same cycle and back-to-back replace with no bubble. With out_ready=0 -> in_ready=0 and M holds.
- Counter saturation: CNT_W=4, stall for 20 cycles -> stall_cycles stops at 15 and stays 15.

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline stage with a valid/ready handshake, an optional skid entry,
// a synchronous flush that inserts a bubble, and a saturating stall counter.
module ex_mem_pipe_stage #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [REG_W-1:0]  dest_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              zero_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic [REG_W-1:0]  dest_reg_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int PW = CTRL_W + 1 + 2 * DATA_W + REG_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   w_in;
    logic [PW-1:0]   r_m;
    logic [PW-1:0]   w_s;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_drain;
    logic            w_load_m_in;
    logic            w_load_m_skid;
    logic            w_load_s;
    logic [CNT_W-1:0] r_stall;

    assign w_in        = {ctrl_in, zero_in, alu_result_in, write_data_in, dest_reg_in};
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid & in_ready;
    assign w_drain     = w_out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [PW-1:0] r_s;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s <= '0;
                end else if (w_load_s) begin
                    r_s <= w_in;
                end
            end

            assign w_s      = r_s;
            // Registered decode only: no path from out_ready to in_ready.
            assign in_ready = (r_state != ST_FULL) & ~flush;
        end else begin : g_single
            assign w_s      = '0;
            assign in_ready = (~w_out_valid | out_ready) & ~flush;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_load_m_in   = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ST_ONE;
                        w_load_m_in  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept) begin
                        // Without a skid entry, accept implies drain in this state.
                        if (w_drain || SKID == 0) begin
                            w_load_m_in = 1'b1;
                        end else begin
                            w_state_next = ST_FULL;
                            w_load_s     = 1'b1;
                        end
                    end else if (w_drain) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_next  = ST_ONE;
                        w_load_m_skid = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m <= '0;
        end else if (w_load_m_in) begin
            r_m <= w_in;
        end else if (w_load_m_skid) begin
            r_m <= w_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_out_valid && !out_ready && r_stall != {CNT_W{1'b1}}) begin
            r_stall <= r_stall + CNT_ONE;
        end
    end

    // Bubbles must never assert MemWrite/RegWrite downstream.
    assign out_valid      = w_out_valid;
    assign ctrl_out       = w_out_valid ? r_m[PW-1 -: CTRL_W] : '0;
    assign zero_out       = w_out_valid & r_m[PW-CTRL_W-1];
    assign alu_result_out = r_m[2*DATA_W+REG_W-1 -: DATA_W];
    assign write_data_out = r_m[DATA_W+REG_W-1 -: DATA_W];
    assign dest_reg_out   = r_m[REG_W-1:0];
    assign occupancy      = r_state;
    assign stall_cycles   = r_stall;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: skid, single-entry and 4-bit-counter instances
// share one stimulus stream and are checked against queue-based models.
module tb_ex_mem_pipe_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, zero_in;
    logic [3:0]  ctrl_in;
    logic [31:0] alu_in, wd_in;
    logic [4:0]  dest_in;

    logic        rdy_1, val_1, zero_1, rdy_0, val_0, zero_0, rdy_4, val_4, zero_4;
    logic [3:0]  ctrl_1, ctrl_0, ctrl_4;
    logic [31:0] alu_1, wd_1, alu_0, wd_0, alu_4, wd_4;
    logic [4:0]  dest_1, dest_0, dest_4;
    logic [1:0]  occ_1, occ_0, occ_4;
    logic [15:0] stall_1, stall_0;
    logic [3:0]  stall_4;

    int total = 0;
    int bad = 0;
    logic [73:0] q1[$];
    logic [73:0] q0[$];
    int stall1 = 0;
    int stall0 = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_stage #(.SKID(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_1),
        .ctrl_in(ctrl_in), .zero_in(zero_in), .alu_result_in(alu_in),
        .write_data_in(wd_in), .dest_reg_in(dest_in), .out_valid(val_1),
        .out_ready(out_ready), .ctrl_out(ctrl_1), .zero_out(zero_1),
        .alu_result_out(alu_1), .write_data_out(wd_1), .dest_reg_out(dest_1),
        .occupancy(occ_1), .stall_cycles(stall_1));

    ex_mem_pipe_stage #(.SKID(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_0),
        .ctrl_in(ctrl_in), .zero_in(zero_in), .alu_result_in(alu_in),
        .write_data_in(wd_in), .dest_reg_in(dest_in), .out_valid(val_0),
        .out_ready(out_ready), .ctrl_out(ctrl_0), .zero_out(zero_0),
        .alu_result_out(alu_0), .write_data_out(wd_0), .dest_reg_out(dest_0),
        .occupancy(occ_0), .stall_cycles(stall_0));

    ex_mem_pipe_stage #(.SKID(1), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_4),
        .ctrl_in(ctrl_in), .zero_in(zero_in), .alu_result_in(alu_in),
        .write_data_in(wd_in), .dest_reg_in(dest_in), .out_valid(val_4),
        .out_ready(out_ready), .ctrl_out(ctrl_4), .zero_out(zero_4),
        .alu_result_out(alu_4), .write_data_out(wd_4), .dest_reg_out(dest_4),
        .occupancy(occ_4), .stall_cycles(stall_4));

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string n, input logic exp_rdy, input int occ,
                             input logic [73:0] front, input int stall, input int smax,
                             input logic o_rdy, input logic o_val, input logic [3:0] o_ctrl,
                             input logic o_zero, input logic [31:0] o_alu, input logic [31:0] o_wd,
                             input logic [4:0] o_dest, input logic [1:0] o_occ, input logic [15:0] o_stall);
        chk({n, ".in_ready"}, 74'(o_rdy), 74'(exp_rdy));
        chk({n, ".out_valid"}, 74'(o_val), 74'(occ > 0));
        chk({n, ".occupancy"}, 74'(o_occ), 74'(occ));
        chk({n, ".stall"}, 74'(o_stall), 74'((stall > smax) ? smax : stall));
        if (occ > 0) begin
            chk({n, ".ctrl"}, 74'(o_ctrl), 74'(front[73:70]));
            chk({n, ".zero"}, 74'(o_zero), 74'(front[69]));
            chk({n, ".alu"}, 74'(o_alu), 74'(front[68:37]));
            chk({n, ".wdata"}, 74'(o_wd), 74'(front[36:5]));
            chk({n, ".dest"}, 74'(o_dest), 74'(front[4:0]));
        end else begin
            chk({n, ".ctrl_bubble"}, 74'(o_ctrl), 74'(0));
            chk({n, ".zero_bubble"}, 74'(o_zero), 74'(0));
        end
    endtask

    task automatic check_all();
        logic [73:0] f1, f0;
        f1 = (q1.size() > 0) ? q1[0] : '0;
        f0 = (q0.size() > 0) ? q0[0] : '0;
        check_one("u1", (q1.size() < 2) && !flush, q1.size(), f1, stall1, 65535,
                  rdy_1, val_1, ctrl_1, zero_1, alu_1, wd_1, dest_1, occ_1, stall_1);
        check_one("u0", (q0.size() == 0 || out_ready) && !flush, q0.size(), f0, stall0, 65535,
                  rdy_0, val_0, ctrl_0, zero_0, alu_0, wd_0, dest_0, occ_0, stall_0);
        check_one("u4", (q1.size() < 2) && !flush, q1.size(), f1, stall1, 15,
                  rdy_4, val_4, ctrl_4, zero_4, alu_4, wd_4, dest_4, occ_4, {12'd0, stall_4});
    endtask

    // Reference: a FIFO of capacity 2 (skid) or 1 (single entry) with flush.
    task automatic model_update();
        logic [73:0] p;
        logic r1, r0, d1, d0;
        p  = {ctrl_in, zero_in, alu_in, wd_in, dest_in};
        r1 = (q1.size() < 2) && !flush;
        r0 = (q0.size() == 0 || out_ready) && !flush;
        d1 = (q1.size() > 0) && out_ready;
        d0 = (q0.size() > 0) && out_ready;
        if (q1.size() > 0 && !out_ready) stall1++;
        if (q0.size() > 0 && !out_ready) stall0++;
        if (flush) q1.delete();
        else begin
            if (d1) void'(q1.pop_front());
            if (in_valid && r1) q1.push_back(p);
        end
        if (flush) q0.delete();
        else begin
            if (d0) void'(q0.pop_front());
            if (in_valid && r0) q0.push_back(p);
        end
    endtask

    task automatic step();
        #1;
        check_all();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [31:0] alu);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        alu_in    = alu;
        ctrl_in   = 4'($urandom);
        zero_in   = 1'($urandom);
        wd_in     = $urandom;
        dest_in   = 5'($urandom);
    endtask

    task automatic reset_checks(input string n);
        chk({n, ".u1.out_valid"}, 74'(val_1), 74'(0));
        chk({n, ".u1.ctrl"}, 74'(ctrl_1), 74'(0));
        chk({n, ".u1.occupancy"}, 74'(occ_1), 74'(0));
        chk({n, ".u1.stall"}, 74'(stall_1), 74'(0));
        chk({n, ".u1.alu"}, 74'(alu_1), 74'(0));
        chk({n, ".u0.out_valid"}, 74'(val_0), 74'(0));
        chk({n, ".u4.stall"}, 74'(stall_4), 74'(0));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        reset_checks("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Streaming 1..8 at full rate
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(i));
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        step();
        step();

        // Backpressure into the skid entry, then release
        drive(1'b1, 1'b0, 1'b0, 32'h10);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h20);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h30);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            step();
        end

        // Flush while full; presented input must never appear
        drive(1'b1, 1'b0, 1'b0, 32'h41);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h42);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        step();
        step();

        // Async reset mid-cycle while full with all control bits set
        drive(1'b1, 1'b0, 1'b0, 32'h51);
        ctrl_in = 4'hF;
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h52);
        ctrl_in = 4'hF;
        step();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check_all();
        #1;
        rst = 1'b1;
        #1;
        reset_checks("async_rst");
        q1.delete();
        q0.delete();
        stall1 = 0;
        stall0 = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Stall counter saturation on the 4-bit instance
        drive(1'b1, 1'b0, 1'b0, 32'h77);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end
        chk("u4.saturated", 74'(stall_4), 74'(15));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            step();
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
